// File: rtl/iob_im_scan_if.sv
// Image memory read port and pixel stream bundle.
// master = scan sequencer, slave = memory wrapper / pixel consumer.
interface iob_im_scan_if #(
  parameter int IM_ADDR_W = 16,
  parameter int IM_DATA_W = 24
);
  logic                 im_r_en;
  logic [IM_ADDR_W-1:0] im_r_addr;
  logic [IM_DATA_W-1:0] im_r_data;
  logic [IM_DATA_W-1:0] pix_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_eol;
  logic                 pix_eof;

  modport master (
    output im_r_en,
    output im_r_addr,
    input  im_r_data,
    output pix_data,
    output pix_valid,
    output pix_eol,
    output pix_eof,
    input  pix_ready
  );

  modport slave (
    input  im_r_en,
    input  im_r_addr,
    output im_r_data,
    input  pix_data,
    input  pix_valid,
    input  pix_eol,
    input  pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/iob_im_scan.sv
// Raster-scan read sequencer for the image memory read port.
// Walks a window row by row and streams pixels with eol/eof markers.
module iob_im_scan #(
  parameter int IM_ADDR_W = 16,
  parameter int IM_DATA_W = 24,
  parameter int DIM_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [IM_ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  input  logic [IM_ADDR_W-1:0] cfg_stride,
  output logic                 busy,
  output logic                 done,
  iob_im_scan_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]     w_q, h_q, col_q, row_q;
  logic [IM_ADDR_W-1:0] stride_q, line_q;

  logic [1:0][IM_DATA_W-1:0] buf_data;
  logic [1:0]                buf_eol, buf_eof;
  logic                      rd_q, wr_q;
  logic [1:0]                cnt_q;

  logic fly_q, fly_eol_q, fly_eof_q;
  logic zdone_q;

  logic zero_cfg, go, last_col, last_row;
  logic pop, issue, drained;
  logic [2:0] credit;

  assign zero_cfg = (cfg_width == '0) || (cfg_height == '0);
  assign go       = start && !abort && (state_q == IDLE);
  assign last_col = (col_q == w_q - DIM_W'(1));
  assign last_row = (row_q == h_q - DIM_W'(1));

  assign pop = bus.pix_valid && bus.pix_ready;

  // Occupancy is counted after this cycle's pop so a full-rate stream
  // keeps one read in flight and one pixel buffered.
  assign credit = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, fly_q};
  assign issue  = (state_q == RUN) && !abort && (credit < 3'd2);

  assign drained = (state_q == DRAIN) && (cnt_q == 2'd0) && !fly_q;

  assign bus.im_r_en   = issue;
  assign bus.im_r_addr = line_q + IM_ADDR_W'(col_q);
  assign bus.pix_valid = (cnt_q != 2'd0);
  assign bus.pix_data  = buf_data[rd_q];
  assign bus.pix_eol   = buf_eol[rd_q];
  assign bus.pix_eof   = buf_eof[rd_q];

  assign busy = (state_q == RUN) || ((state_q == DRAIN) && !drained);
  assign done = drained || zdone_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && !zero_cfg) state_d = RUN;
        RUN:     if (issue && last_col && last_row) state_d = DRAIN;
        DRAIN:   if (drained) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= '0;
      h_q       <= '0;
      stride_q  <= '0;
      line_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      fly_q     <= 1'b0;
      fly_eol_q <= 1'b0;
      fly_eof_q <= 1'b0;
      zdone_q   <= 1'b0;
    end else begin
      zdone_q <= go && zero_cfg;
      fly_q   <= issue;
      if (go) begin
        w_q      <= cfg_width;
        h_q      <= cfg_height;
        stride_q <= cfg_stride;
        line_q   <= cfg_base;
        col_q    <= '0;
        row_q    <= '0;
      end else if (issue) begin
        fly_eol_q <= last_col;
        fly_eof_q <= last_col && last_row;
        if (last_col) begin
          col_q  <= '0;
          row_q  <= row_q + DIM_W'(1);
          line_q <= line_q + stride_q;
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      buf_eol  <= '0;
      buf_eof  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (abort) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (fly_q) begin
        buf_data[wr_q] <= bus.im_r_data;
        buf_eol[wr_q]  <= fly_eol_q;
        buf_eof[wr_q]  <= fly_eof_q;
        wr_q           <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, fly_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_iob_im_scan.sv
// Directed bench for iob_im_scan.
// Memory model returns {A5, addr} one cycle after each read.
module tb_iob_im_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_base;
  logic [9:0]  cfg_width;
  logic [9:0]  cfg_height;
  logic [15:0] cfg_stride;
  logic        busy;
  logic        done;
  logic [23:0] rdata;
  logic [7:0]  lfsr;

  int n_checks = 0;
  int n_errors = 0;

  iob_im_scan_if #(.IM_ADDR_W(16), .IM_DATA_W(24)) bus ();

  iob_im_scan #(
    .IM_ADDR_W(16),
    .IM_DATA_W(24),
    .DIM_W(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .cfg_base(cfg_base),
    .cfg_width(cfg_width),
    .cfg_height(cfg_height),
    .cfg_stride(cfg_stride),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.im_r_data = rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (bus.im_r_en) rdata <= {8'hA5, bus.im_r_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode bit0: pseudo-random pix_ready; bit1: restart + cfg change mid-frame
  task automatic run_frame(input logic [15:0] base, input logic [9:0] w,
                           input logic [9:0] h, input logic [15:0] stride,
                           input int mode, input int abort_at);
    int total;
    int iss;
    int xf;
    int cyc;
    int last_x;
    int stall;
    int pend;
    bit fin;
    bit pv;
    bit pr;
    logic [23:0] pd;
    logic [15:0] ea;
    total  = int'(w) * int'(h);
    iss    = 0;
    xf     = 0;
    cyc    = 0;
    last_x = -1;
    stall  = 0;
    fin    = 0;
    pv     = 0;
    pr     = 0;
    pd     = '0;
    @(negedge clk);
    cfg_base   = base;
    cfg_width  = w;
    cfg_height = h;
    cfg_stride = stride;
    start      = 1'b1;
    bus.pix_ready = 1'b1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (mode[1] && cyc == 4) begin
        start      = 1'b1;
        cfg_base   = 16'h7777;
        cfg_width  = 10'd1;
        cfg_height = 10'd1;
        cfg_stride = 16'd3;
      end
      if (abort_at > 0 && xf == abort_at) begin
        stall++;
        if (stall == 3) abort = 1'b1;
        bus.pix_ready = 1'b0;
      end else begin
        bus.pix_ready = mode[0] ? lfsr[0] : 1'b1;
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      #1;
      if (stall == 4) begin
        check("abort_busy", busy, 0);
        check("abort_valid", bus.pix_valid, 0);
        check("abort_done", done, 0);
        fin = 1;
      end else begin
        if (cyc == 1) check("first_rd_lat", bus.im_r_en, 1);
        if (pv && !pr) check("stall_hold", bus.pix_data, pd);
        if (bus.im_r_en) begin
          ea = base + 16'(iss / int'(w)) * stride + 16'(iss % int'(w));
          check("rd_addr", bus.im_r_addr, ea);
          pend = iss - xf - ((bus.pix_valid && bus.pix_ready) ? 1 : 0);
          check("credit", pend < 2, 1);
          iss++;
        end
        if (bus.pix_valid && bus.pix_ready) begin
          ea = base + 16'(xf / int'(w)) * stride + 16'(xf % int'(w));
          check("pix_data", bus.pix_data, {8'hA5, ea});
          check("pix_eol", bus.pix_eol, (xf % int'(w)) == int'(w) - 1);
          check("pix_eof", bus.pix_eof, xf == total - 1);
          if (mode == 0) check("b2b_cycle", cyc, xf + 3);
          xf++;
          last_x = cyc;
        end
        if (done) begin
          check("done_busy", busy, 0);
          check("done_count", xf, total);
          check("done_lat", cyc, last_x + 1);
          fin = 1;
        end
        pv = bus.pix_valid;
        pr = bus.pix_ready;
        pd = bus.pix_data;
      end
    end
    if (!fin) check("timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_base = '0;
    cfg_width = '0;
    cfg_height = '0;
    cfg_stride = '0;
    bus.pix_ready = 1'b0;
    lfsr = 8'hB5;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", {busy, done, bus.im_r_en, bus.pix_valid}, 0);
    check("rst_addr", bus.im_r_addr, 0);
    check("rst_pix", {bus.pix_data, bus.pix_eol, bus.pix_eof}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(16'h0100, 10'd4, 10'd3, 16'd8, 0, 0);
    run_frame(16'h0100, 10'd4, 10'd3, 16'd8, 1, 0);

    @(negedge clk);
    cfg_width  = 10'd0;
    cfg_height = 10'd5;
    start      = 1'b1;
    #1;
    check("zero_en0", bus.im_r_en, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_en1", bus.im_r_en, 0);
    @(negedge clk);
    #1;
    check("zero_done_off", done, 0);
    check("zero_busy_off", busy, 0);

    run_frame(16'hFFFE, 10'd4, 10'd1, 16'd0, 0, 0);
    run_frame(16'h0100, 10'd4, 10'd3, 16'd8, 0, 5);
    @(negedge clk);
    #1;
    check("post_abort_done", done, 0);
    run_frame(16'h0100, 10'd4, 10'd3, 16'd8, 0, 0);
    run_frame(16'h0100, 10'd4, 10'd3, 16'd8, 2, 0);

    @(negedge clk);
    cfg_base   = 16'h0200;
    cfg_width  = 10'd4;
    cfg_height = 10'd3;
    cfg_stride = 16'd8;
    start      = 1'b1;
    bus.pix_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {busy, done, bus.im_r_en, bus.pix_valid}, 0);
    check("mid_rst_addr", bus.im_r_addr, 0);
    check("mid_rst_pix", {bus.pix_data, bus.pix_eol, bus.pix_eof}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(16'h0042, 10'd1, 10'd1, 16'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
